// File: rtl/rgb_pwm_pkg.sv
// Shared constants, channel indices, LED polarity and duty clamp for the RGB PWM driver.
// RGB_PWM_ACTIVE_LOW_EN selects active-low LED pins (common-anode boards).
package rgb_pwm_pkg;

  localparam int unsigned PWM_INTERVAL_DEF = 1200;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic LED_ACTIVE   = 1'b0;
  localparam logic LED_INACTIVE = 1'b1;
`else
  localparam logic LED_ACTIVE   = 1'b1;
  localparam logic LED_INACTIVE = 1'b0;
`endif

  // Anything at or above the period length means "on for the whole period".
  function automatic int unsigned clamp_duty(input int unsigned v, input int unsigned interval);
    return (v >= interval) ? interval : v;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: clamped shadow duty register, compare against the shared counter, output flop.
// Polarity follows RGB_PWM_ACTIVE_LOW_EN via the package LED levels.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DUTY_W-1:0] cnt,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              led
);

  // Shadow must hold PWM_INTERVAL itself, which may not fit in DUTY_W bits.
  localparam int unsigned SH_W = $clog2(PWM_INTERVAL + 1);

  logic [SH_W-1:0] shadow_q, shadow_d;
  logic            led_q, led_d;

  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
      shadow_d = SH_W'(clamp_duty(32'(duty_in), PWM_INTERVAL));
    end
    led_d = (en && (32'(cnt) < 32'(shadow_q))) ? LED_ACTIVE : LED_INACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      led_q    <= LED_INACTIVE;
    end else begin
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel glitch-free PWM LED driver: shared period counter, per-channel shadowed duty.
// Build with RGB_PWM_ACTIVE_LOW_EN for active-low (common-anode) LED pins.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] pwm_value_R,
  input  logic [DUTY_W-1:0] pwm_value_G,
  input  logic [DUTY_W-1:0] pwm_value_B,
  output logic              led_R,
  output logic              led_G,
  output logic              led_B,
  output logic              period_start
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_INTERVAL - 1);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              period_start_q, period_start_d;
  logic              load;
  logic [DUTY_W-1:0] duty_in [3];
  logic [2:0]        led_vec;

  // Shadows track the inputs continuously while idle so en rising starts with fresh duties.
  assign load = !en || (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + DUTY_W'(1);
    end
    period_start_d = en && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign duty_in[CH_R] = pwm_value_R;
  assign duty_in[CH_G] = pwm_value_G;
  assign duty_in[CH_B] = pwm_value_B;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    pwm_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .DUTY_W       (DUTY_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .cnt     (cnt_q),
      .duty_in (duty_in[i]),
      .led     (led_vec[i])
    );
  end

  assign led_R        = led_vec[CH_R];
  assign led_G        = led_vec[CH_G];
  assign led_B        = led_vec[CH_B];
  assign period_start = period_start_q;

endmodule
